// File: rtl/cheshire_clk_div_pkg.sv
// Shared divisor type and clamp rules for the programmable clock divider bank.
package cheshire_clk_div_pkg;

  localparam int unsigned MaxCntWidth = 32;

  typedef logic [MaxCntWidth-1:0] div_t;

  localparam div_t DivPark = '0;
  localparam div_t DivMin  = div_t'(2);

  typedef enum logic [1:0] {
    ChanRun,
    ChanDrain,
    ChanStop
  } chan_state_e;

  // Divide-by-one cannot produce a clock edge pair, so it is widened to the minimum.
  function automatic div_t eff_div(div_t div);
    if (div != DivPark && div < DivMin) return DivMin;
    return div;
  endfunction

endpackage

// File: rtl/cheshire_clk_div_chan.sv
// One divider channel: counter, shadow divisor with ready handshake, run/drain/stop control.
module cheshire_clk_div_chan
  import cheshire_clk_div_pkg::*;
#(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned DefaultDiv = 50
) (
  input  logic                soc_clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [CntWidth-1:0] div_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  output logic                clk_o,
  output logic                tick_o
);

  typedef logic [CntWidth-1:0] cnt_t;

  chan_state_e state_q, state_d;
  cnt_t        cnt_q, cnt_d, div_q, div_d, shadow_q;
  cnt_t        n_act, n_next, n_shadow;
  logic        shadow_valid_q, shadow_valid_d;
  logic        clk_q, tick_q;
  logic        running, wrap, apply, xfer;

  function automatic cnt_t clamp(cnt_t d);
    return cnt_t'(eff_div(div_t'(d)));
  endfunction

  // A new divisor only takes effect on a period boundary (or immediately when idle),
  // so the running period is never cut short or stretched.
  always_comb begin
    running        = (state_q != ChanStop);
    n_act          = clamp(div_q);
    n_shadow       = clamp(shadow_q);
    wrap           = running && (cnt_q == n_act - cnt_t'(1));
    apply          = shadow_valid_q && (wrap || !running);
    xfer           = div_valid_i && !shadow_valid_q;
    div_d          = apply ? shadow_q : div_q;
    n_next         = clamp(div_d);
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_valid_d = shadow_valid_q;

    if (!running) begin
      if (en_i && n_next != '0) begin
        state_d = ChanRun;
        cnt_d   = cnt_t'(1);
      end else begin
        state_d = ChanStop;
        cnt_d   = '0;
      end
    end else if (wrap) begin
      cnt_d   = '0;
      state_d = (en_i && n_next != '0) ? ChanRun : ChanStop;
    end else begin
      cnt_d   = cnt_q + cnt_t'(1);
      state_d = (en_i && !(shadow_valid_q && n_shadow == '0)) ? ChanRun : ChanDrain;
    end

    if (xfer) begin
      shadow_valid_d = 1'b1;
    end else if (apply) begin
      shadow_valid_d = 1'b0;
    end
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ChanStop;
      cnt_q          <= '0;
      div_q          <= cnt_t'(DefaultDiv);
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      clk_q          <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      shadow_valid_q <= shadow_valid_d;
      if (xfer) shadow_q <= div_i;
      clk_q          <= (n_next != '0) && (cnt_d >= (n_next >> 1));
      tick_q         <= (n_next != '0) && (cnt_d == n_next - cnt_t'(1));
    end
  end

  assign div_ready_o = !shadow_valid_q;
  assign clk_o       = clk_q;
  assign tick_o      = tick_q;

endmodule

// File: rtl/cheshire_clk_div_bank.sv
// Bank of independent programmable clock dividers; channel 0 feeds the RTC.
module cheshire_clk_div_bank
  import cheshire_clk_div_pkg::*;
#(
  parameter int unsigned NumChannels = 1,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned DefaultDiv  = 50
) (
  input  logic                            soc_clk,
  input  logic                            rst_n,
  input  logic [NumChannels-1:0]          en_i,
  input  logic [NumChannels*CntWidth-1:0] div_i,
  input  logic [NumChannels-1:0]          div_valid_i,
  output logic [NumChannels-1:0]          div_ready_o,
  output logic [NumChannels-1:0]          clk_o,
  output logic [NumChannels-1:0]          tick_o
);

  for (genvar ch = 0; ch < NumChannels; ch++) begin : gen_chan
    cheshire_clk_div_chan #(
      .CntWidth  (CntWidth),
      .DefaultDiv(DefaultDiv)
    ) u_chan (
      .soc_clk    (soc_clk),
      .rst_n      (rst_n),
      .en_i       (en_i[ch]),
      .div_i      (div_i[ch*CntWidth +: CntWidth]),
      .div_valid_i(div_valid_i[ch]),
      .div_ready_o(div_ready_o[ch]),
      .clk_o      (clk_o[ch]),
      .tick_o     (tick_o[ch])
    );
  end

endmodule

// File: tb/tb_cheshire_clk_div_bank.sv
// Self-checking bench: directed scenarios plus random enables/updates against a period-level model.
module tb_cheshire_clk_div_bank;

  localparam int NCH = 2;
  localparam int CW  = 16;

  logic            soc_clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic [NCH*CW-1:0] div_bus;
  logic [NCH-1:0]  div_valid;
  logic [NCH-1:0]  div_ready;
  logic [NCH-1:0]  clk_div;
  logic [NCH-1:0]  tick;

  int checks   = 0;
  int failures = 0;

  // Model: pos = position within the current period, -1 when stopped/parked.
  int pos      [NCH];
  int per      [NCH];
  int pend_val [NCH];
  bit pend_has [NCH];
  bit accepted [NCH];

  always #5 soc_clk = ~soc_clk;

  cheshire_clk_div_bank #(
    .NumChannels(NCH),
    .CntWidth   (CW),
    .DefaultDiv (50)
  ) dut (
    .soc_clk    (soc_clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .div_i      (div_bus),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready),
    .clk_o      (clk_div),
    .tick_o     (tick)
  );

  function automatic int effDiv(int d);
    return (d == 1) ? 2 : d;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      pos[c] = -1; per[c] = 50; pend_has[c] = 0; pend_val[c] = 0; accepted[c] = 0;
    end
  endtask

  task automatic modelStep();
    for (int c = 0; c < NCH; c++) begin
      bit xfer;
      accepted[c] = 0;
      xfer = div_valid[c] && !pend_has[c];
      if (pos[c] >= 0) begin
        if (pos[c] == effDiv(per[c]) - 1) begin
          if (pend_has[c]) begin per[c] = pend_val[c]; pend_has[c] = 0; end
          pos[c] = (en[c] && per[c] != 0) ? 0 : -1;
        end else begin
          pos[c]++;
        end
      end else begin
        if (pend_has[c]) begin per[c] = pend_val[c]; pend_has[c] = 0; end
        if (en[c] && per[c] != 0) pos[c] = 1;
      end
      if (xfer) begin
        pend_has[c] = 1;
        pend_val[c] = int'(div_bus[c*CW +: CW]);
        accepted[c] = 1;
      end
    end
  endtask

  task automatic compareAll();
    for (int c = 0; c < NCH; c++) begin
      bit exp_clk, exp_tick;
      exp_clk  = (pos[c] >= 0) && (pos[c] >= effDiv(per[c]) / 2);
      exp_tick = (pos[c] >= 0) && (pos[c] == effDiv(per[c]) - 1);
      checkOutput($sformatf("clk_o[%0d]", c), 32'(clk_div[c]), 32'(exp_clk));
      checkOutput($sformatf("tick_o[%0d]", c), 32'(tick[c]), 32'(exp_tick));
      checkOutput($sformatf("div_ready_o[%0d]", c), 32'(div_ready[c]), 32'(!pend_has[c]));
    end
  endtask

  // One soc_clk cycle: model advances on the edge, outputs checked 1 ns later, return at negedge.
  task automatic applyStimulus();
    @(posedge soc_clk);
    if (rst_n) modelStep();
    else       modelReset();
    #1;
    compareAll();
    @(negedge soc_clk);
  endtask

  task automatic writeDiv(int c, int n);
    int k;
    div_bus[c*CW +: CW] = CW'(n);
    div_valid[c] = 1'b1;
    k = 0;
    do begin
      applyStimulus();
      k++;
    end while (!accepted[c] && k < 200);
    div_valid[c] = 1'b0;
    if (!accepted[c]) checkOutput("write_timeout", 0, 1);
  endtask

  task automatic waitReady(int c);
    int k = 0;
    while (!div_ready[c] && k < 200) begin applyStimulus(); k++; end
    if (!div_ready[c]) checkOutput("ready_timeout", 0, 1);
  endtask

  task automatic waitTick(int c);
    int k = 0;
    do begin applyStimulus(); k++; end while (!tick[c] && k < 200);
    if (!tick[c]) checkOutput("tick_timeout", 0, 1);
  endtask

  task automatic measureTickPeriod(int c, int expected, string tag);
    int k = 0;
    waitTick(c);
    do begin applyStimulus(); k++; end while (!tick[c] && k < 200);
    checkOutput(tag, k, expected);
  endtask

  task automatic countRise(int c, int expected, string tag);
    int k = 0;
    do begin applyStimulus(); k++; end while (!clk_div[c] && k < 200);
    checkOutput(tag, k, expected);
  endtask

  initial begin
    int k;
    int ticks_seen;
    rst_n     = 1'b0;
    en        = '0;
    div_valid = '0;
    div_bus   = '0;
    modelReset();
    applyStimulus();
    applyStimulus();
    checkOutput("reset_clk", 32'(clk_div), 0);
    checkOutput("reset_tick", 32'(tick), 0);
    checkOutput("reset_ready", 32'(div_ready), 32'(2'b11));

    // Default divide-by-50 after reset
    en    = 2'b11;
    rst_n = 1'b1;
    countRise(0, 25, "rise_after_reset");
    measureTickPeriod(0, 50, "tick_period_50");

    // N=5
    writeDiv(0, 5);
    waitReady(0);
    measureTickPeriod(0, 5, "tick_period_5");

    // Update mid-period at cnt 7 of a 50 period: ready held until the wrap
    writeDiv(0, 50);
    waitReady(0);
    waitTick(0);
    for (int i = 0; i < 8; i++) applyStimulus();
    writeDiv(0, 10);
    k = 0;
    while (!div_ready[0] && k < 200) begin applyStimulus(); k++; end
    checkOutput("ready_low_cycles", k, 42);
    measureTickPeriod(0, 10, "tick_period_10");

    // N=1 clamps to 2, N=0 parks, N=8 restarts
    writeDiv(0, 1);
    waitReady(0);
    measureTickPeriod(0, 2, "tick_period_1as2");
    writeDiv(0, 0);
    waitReady(0);
    ticks_seen = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      ticks_seen += int'(tick[0]);
    end
    checkOutput("park_ticks", ticks_seen, 0);
    checkOutput("park_clk", 32'(clk_div[0]), 0);
    writeDiv(0, 8);
    waitReady(0);
    measureTickPeriod(0, 8, "tick_period_8");

    // Enable dropped at cnt 30 of a 50 period: high phase finishes, then stop
    writeDiv(0, 50);
    waitReady(0);
    waitTick(0);
    for (int i = 0; i < 31; i++) applyStimulus();
    en[0] = 1'b0;
    k = 0;
    while (clk_div[0] && k < 200) begin applyStimulus(); k++; end
    checkOutput("drain_cycles", k, 20);
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("stopped_clk", 32'(clk_div[0]), 0);
    en[0] = 1'b1;
    countRise(0, 25, "rise_after_enable");

    // Random enables and divisor updates on both channels
    for (int i = 0; i < 2500; i++) begin
      int vals[11] = '{0, 1, 2, 3, 4, 5, 7, 8, 10, 13, 50};
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        div_valid[c] = ($urandom_range(0, 14) == 0);
        div_bus[c*CW +: CW] = CW'(vals[$urandom_range(0, 10)]);
      end
      applyStimulus();
    end
    div_valid = '0;
    en        = 2'b11;

    // Async reset mid-update with the channels at different divisors
    writeDiv(1, 12);
    waitReady(1);
    writeDiv(0, 7);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset_clk", 32'(clk_div), 0);
    checkOutput("async_reset_tick", 32'(tick), 0);
    checkOutput("async_reset_ready", 32'(div_ready), 32'(2'b11));
    @(negedge soc_clk);
    applyStimulus();
    rst_n = 1'b1;
    countRise(1, 25, "rise_ch1_after_reset");
    checkOutput("rise_ch0_in_phase", 32'(clk_div[0]), 1);
    measureTickPeriod(0, 50, "tick_period_ch0_post_reset");
    measureTickPeriod(1, 50, "tick_period_ch1_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
